// File: rtl/scroll_pkg.sv
// Types, message ROM and window helper for the scrolling display controller.
`include "defines.sv"

package scroll_pkg;

    typedef enum logic [1:0] {INIT, RUN, PAUSED} state_t;

    localparam int MSG_LEN = 8;
    localparam int SW      = $clog2(MSG_LEN);

    typedef logic [SW-1:0] idx_t;

    localparam logic [6:0] MSG_ROM [MSG_LEN] = '{
        `HEX_C, `HEX_P, `HEX_E, `HEX_N, `HEX_OFF, `HEX_3, `HEX_1, `HEX_1
    };

    // Six-character window starting at s; element 5 is HEX5 (leftmost)
    function automatic logic [5:0][6:0] window(idx_t s);
        logic [5:0][6:0] w;
        for (int i = 0; i < 6; i++) begin
            w[5-i] = MSG_ROM[idx_t'((int'(s) + i) % MSG_LEN)];
        end
        return w;
    endfunction

endpackage

// File: rtl/defines.sv
// Board-level constants shared by the design and its benches.
`ifndef DEFINES_SV
`define DEFINES_SV

`define CLOCK_CYCLE 10

// Active-low seven-segment codes, bit order {g,f,e,d,c,b,a}
`define HEX_C   7'b1000110
`define HEX_P   7'b0001100
`define HEX_E   7'b0000110
`define HEX_N   7'b0101011
`define HEX_OFF 7'b1111111
`define HEX_3   7'b0110000
`define HEX_1   7'b1111001

`endif

// File: rtl/scroll_controller_tick_divider.sv
// Rate divider: counts 0..TICKS_PER_STEP-1 while run is high and pulses tick
// during the terminal-count cycle. Holds its value while run is low.
module tick_divider #(
    parameter int TICKS_PER_STEP = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICKS_PER_STEP - 1);

    logic [CW-1:0] count;

    assign tick = run && (count == TERM);

    // Advance only while running; wrap at terminal count
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (run)
            count <= (count == TERM) ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/scroll_controller.sv
// Scroll controller: FSM, start index and registered six-character window
// with one-cycle load strobes for the display datapath.
import scroll_pkg::*;

module scroll_controller #(
    parameter int TICKS_PER_STEP = 50_000_000,
    parameter int MSG_LEN        = scroll_pkg::MSG_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       dir,
    output logic       hex_en,
    output logic       ledr_en,
    output logic [6:0] next_hex0,
    output logic [6:0] next_hex1,
    output logic [6:0] next_hex2,
    output logic [6:0] next_hex3,
    output logic [6:0] next_hex4,
    output logic [6:0] next_hex5
);

    state_t          state, state_nxt;
    idx_t            s, s_nxt;
    logic            hex_d, ledr_d;
    logic            tick;
    logic [5:0][6:0] hex_q;

    // The divider runs in RUN and also in the PAUSED cycle where pause has
    // already dropped, so each paused cycle costs exactly one cycle.
    tick_divider #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_div (
        .clk   (clk),
        .reset (reset),
        .run   ((state != INIT) && !pause),
        .tick  (tick)
    );

    // Next state, next start index and strobe requests
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        hex_d     = 1'b0;
        ledr_d    = 1'b0;
        case (state)
            INIT: begin
                state_nxt = RUN;
                s_nxt     = '0;
                hex_d     = 1'b1;
            end
            RUN:     if (pause)  state_nxt = PAUSED;
            PAUSED:  if (!pause) state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
        if (tick) begin
            if (dir)
                s_nxt = (s == idx_t'(MSG_LEN - 1)) ? '0 : s + 1'b1;
            else
                s_nxt = (s == '0) ? idx_t'(MSG_LEN - 1) : s - 1'b1;
            hex_d  = 1'b1;
            ledr_d = (s_nxt == '0);
        end
    end

    // State, index, strobes and window registers; window loads with the strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT;
            s       <= '0;
            hex_en  <= 1'b0;
            ledr_en <= 1'b0;
            hex_q   <= window('0);
        end else begin
            state   <= state_nxt;
            s       <= s_nxt;
            hex_en  <= hex_d;
            ledr_en <= ledr_d;
            if (hex_d)
                hex_q <= window(s_nxt);
        end
    end

    assign next_hex0 = hex_q[0];
    assign next_hex1 = hex_q[1];
    assign next_hex2 = hex_q[2];
    assign next_hex3 = hex_q[3];
    assign next_hex4 = hex_q[4];
    assign next_hex5 = hex_q[5];

endmodule

// File: tb/tb_scroll_controller.sv
// Directed bench for scroll_controller with a strobe scoreboard.
`include "defines.sv"

module tb_scroll_controller;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       reset, pause, dir;
    logic       hex_en, ledr_en;
    logic [6:0] h0, h1, h2, h3, h4, h5;

    scroll_controller #(.TICKS_PER_STEP(TPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .pause     (pause),
        .dir       (dir),
        .hex_en    (hex_en),
        .ledr_en   (ledr_en),
        .next_hex0 (h0),
        .next_hex1 (h1),
        .next_hex2 (h2),
        .next_hex3 (h3),
        .next_hex4 (h4),
        .next_hex5 (h5)
    );

    always #(`CLOCK_CYCLE/2) clk = ~clk;

    typedef struct {
        int          cyc;
        logic        ledr;
        logic [41:0] win;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   vectors  = 0;
    int   fails    = 0;
    bit   mon_en   = 1'b0;

    logic [6:0] rom [8] = '{`HEX_C, `HEX_P, `HEX_E, `HEX_N,
                            `HEX_OFF, `HEX_3, `HEX_1, `HEX_1};

    wire [41:0] dut_win = {h5, h4, h3, h2, h1, h0};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [41:0] win(logic [2:0] s);
        logic [41:0] w;
        for (int i = 0; i < 6; i++) w[41-7*i -: 7] = rom[3'(s + 3'(i))];
        return w;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(int c, logic [2:0] s, logic l);
        exp_t e;
        e.cyc = c; e.ledr = l; e.win = win(s);
        sb.push_back(e);
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard: every strobe must match the queue head in cycle, ledr and window
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("missed_strobe", 64'(cyc), 64'(sb[0].cyc));
                void'(sb.pop_front());
            end
            if (hex_en) begin
                exp_t e;
                e.cyc = -1; e.ledr = 1'bx; e.win = '1;
                if (sb.size() > 0) e = sb.pop_front();
                chk("strobe_cycle",  64'(cyc),     64'(e.cyc));
                chk("strobe_ledr",   64'(ledr_en), 64'(e.ledr));
                chk("strobe_window", 64'(dut_win), 64'(e.win));
            end
        end
    end

    initial begin
        int          r;
        logic [2:0]  ms;

        reset = 1'b1; pause = 1'b0; dir = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hex_en",  64'(hex_en),  64'(0));
        chk("rst_ledr_en", 64'(ledr_en), 64'(0));
        chk("rst_window",  64'(dut_win), 64'(win(3'd0)));

        // Release; INIT strobe then 8 leftward steps
        r = cyc;
        mon_en = 1'b1;
        reset = 1'b0;
        ms = 3'd0;
        push(r + 1, ms, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            ms = ms - 3'd1;
            push(r + 1 + TPS*k, ms, ms == 3'd0);
        end
        wait_cyc(r + 34);

        // Reverse direction mid-count; 8 rightward steps
        dir = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            ms = ms + 3'd1;
            push(r + 33 + TPS*k, ms, ms == 3'd0);
        end

        // Pause 10 cycles starting where count is 2
        wait_cyc(r + 67);
        pause = 1'b1;
        wait_cyc(r + 72);
        chk("pause_hex_en", 64'(hex_en),  64'(0));
        chk("pause_window", 64'(dut_win), 64'(win(3'd0)));
        wait_cyc(r + 77);
        pause = 1'b0;
        push(r + 79, 3'd1, 1'b0);
        push(r + 83, 3'd2, 1'b0);

        // Reset during the strobe cycle at r+83
        wait_cyc(r + 83);
        reset = 1'b1;
        wait_cyc(r + 84);
        chk("midrst_hex_en",  64'(hex_en),  64'(0));
        chk("midrst_ledr_en", 64'(ledr_en), 64'(0));
        chk("midrst_window",  64'(dut_win), 64'(win(3'd0)));
        reset = 1'b0;
        push(r + 85, 3'd0, 1'b0);
        push(r + 89, 3'd1, 1'b0);
        wait_cyc(r + 92);
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
